// File: rtl/counter_xn_if.sv
// Bus-side register port of the multi-channel timer/counter.
// Carries the write strobe, select, write data and read-back value.
interface counter_xn_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
);
    logic             counter_we;
    logic [SEL_W-1:0] counter_ch;
    logic [31:0]      counter_val;
    logic [WIDTH-1:0] counter_out;

    modport master (
        output counter_we,
        output counter_ch,
        output counter_val,
        input  counter_out
    );

    modport slave (
        input  counter_we,
        input  counter_ch,
        input  counter_val,
        output counter_out
    );
endinterface

// File: rtl/counter_xn.sv
// Parametrised multi-channel timer/counter with per-channel mode,
// enable, synchronised tick inputs and maskable pending interrupts.
module counter_xn #(
    parameter int N_CH  = 3,
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
) (
    input  logic            clk,
    input  logic            RSTN,
    input  logic [N_CH-1:0] cnt_clk,
    input  logic [N_CH-1:0] irq_ack,
    counter_xn_if.slave     bus,
    output logic [N_CH-1:0] counter_tc,
    output logic [N_CH-1:0] irq_pend,
    output logic            irq
);
    localparam int CW = 4 * N_CH;
    localparam logic [SEL_W-1:0] CTRL_SEL = SEL_W'(N_CH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [1:0] M_ONESHOT = 2'b00;
    localparam logic [1:0] M_RELOAD  = 2'b01;
    localparam logic [1:0] M_SQUARE  = 2'b10;
    localparam logic [1:0] M_FREE    = 2'b11;

    logic [WIDTH-1:0] cnt_q [N_CH];
    logic [WIDTH-1:0] cnt_d [N_CH];
    logic [WIDTH-1:0] rld_q [N_CH];
    logic [WIDTH-1:0] rld_d [N_CH];
    logic [CW-1:0]    ctrl_q, ctrl_d;
    logic [N_CH-1:0]  tc_q, tc_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  s1_q, s2_q, s3_q;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  evt;
    logic [N_CH-1:0]  ien;
    logic             ctrl_we;
    logic [WIDTH-1:0] rd;
    logic             unused_val;

    // Upper write-data bits are only meaningful for wide configurations.
    assign unused_val = ^bus.counter_val;

    assign tick    = s2_q & ~s3_q;
    assign ctrl_we = bus.counter_we && (bus.counter_ch == CTRL_SEL);

    // Next-state for control, counts, reloads, tc flags and pending flags.
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_we) begin
            ctrl_d = bus.counter_val[CW-1:0];
        end
        tc_d   = tc_q;
        pend_d = pend_q;
        evt    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            rld_d[i] = rld_q[i];
            // Rate-generator output is a single-cycle strobe.
            if (ctrl_q[4*i +: 2] == M_RELOAD) begin
                tc_d[i] = 1'b0;
            end
            if (bus.counter_we && (bus.counter_ch == SEL_W'(i))) begin
                cnt_d[i] = bus.counter_val[WIDTH-1:0];
                rld_d[i] = bus.counter_val[WIDTH-1:0];
                tc_d[i]  = 1'b0;
            end else if (tick[i] && ctrl_q[4*i+2]) begin
                unique case (ctrl_q[4*i +: 2])
                    M_ONESHOT: begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end
                        if (cnt_q[i] == ONE) begin
                            evt[i]  = 1'b1;
                            tc_d[i] = 1'b1;
                        end
                    end
                    M_RELOAD, M_SQUARE: begin
                        if (cnt_q[i] == ONE) begin
                            cnt_d[i] = rld_q[i];
                            evt[i]   = 1'b1;
                            if (ctrl_q[4*i +: 2] == M_RELOAD) begin
                                tc_d[i] = 1'b1;
                            end else begin
                                tc_d[i] = ~tc_q[i];
                            end
                        end else if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end
                    end
                    M_FREE: begin
                        cnt_d[i] = cnt_q[i] + ONE;
                        evt[i]   = &cnt_q[i];
                    end
                    default: ;
                endcase
            end
            if (ctrl_we && (ctrl_d[4*i +: 2] != ctrl_q[4*i +: 2])) begin
                tc_d[i] = 1'b0;
            end
            pend_d[i] = (pend_q[i] & ~irq_ack[i]) | evt[i];
        end
    end

    // State registers and tick synchronisers.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                rld_q[i] <= '0;
            end
            ctrl_q <= '0;
            tc_q   <= '0;
            pend_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                rld_q[i] <= rld_d[i];
            end
            ctrl_q <= ctrl_d;
            tc_q   <= tc_d;
            pend_q <= pend_d;
            s1_q   <= cnt_clk;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
        end
    end

    // Per-channel output select; free-run mode shows the count MSB.
    always_comb begin
        counter_tc = '0;
        ien        = '0;
        for (int i = 0; i < N_CH; i++) begin
            ien[i] = ctrl_q[4*i+3];
            if (ctrl_q[4*i +: 2] == M_FREE) begin
                counter_tc[i] = cnt_q[i][WIDTH-1];
            end else begin
                counter_tc[i] = tc_q[i];
            end
        end
    end

    // Read-back mux: a channel count, else the control register.
    always_comb begin
        rd = WIDTH'(ctrl_q);
        for (int i = 0; i < N_CH; i++) begin
            if (bus.counter_ch == SEL_W'(i)) begin
                rd = cnt_q[i];
            end
        end
    end

    assign bus.counter_out = rd;
    assign irq_pend        = pend_q;
    assign irq             = |(pend_q & ien);
endmodule

// File: tb/tb_counter_xn.sv
// Directed self-checking bench for counter_xn.
// Three channels, 8-bit counts, 3-bit select.
module tb_counter_xn;
    localparam int N_CH  = 3;
    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic            clk;
    logic            RSTN;
    logic [N_CH-1:0] cnt_clk;
    logic [N_CH-1:0] irq_ack;
    logic [N_CH-1:0] counter_tc;
    logic [N_CH-1:0] irq_pend;
    logic            irq;

    logic [N_CH-1:0] tc_at, tc_nx, pend_at;
    logic            irq_at;
    int              errors;
    int              checks;

    counter_xn_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    counter_xn #(
        .N_CH (N_CH),
        .WIDTH(WIDTH),
        .SEL_W(SEL_W)
    ) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .cnt_clk   (cnt_clk),
        .irq_ack   (irq_ack),
        .bus       (bus),
        .counter_tc(counter_tc),
        .irq_pend  (irq_pend),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int ch,
                           input logic [31:0] exp);
        bus.counter_ch = SEL_W'(ch);
        #1;
        chk(tag, 32'(bus.counter_out), exp);
    endtask

    task automatic wr(input int ch, input logic [31:0] val);
        @(negedge clk);
        bus.counter_we  = 1'b1;
        bus.counter_ch  = SEL_W'(ch);
        bus.counter_val = val;
        @(negedge clk);
        bus.counter_we  = 1'b0;
    endtask

    // One cnt_clk pulse; ack is driven in the cycle the tick is seen.
    task automatic pulse(input int i, input logic [N_CH-1:0] ack);
        @(negedge clk);
        cnt_clk[i] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        irq_ack = ack;
        @(negedge clk);
        irq_ack = '0;
        tc_at   = counter_tc;
        pend_at = irq_pend;
        irq_at  = irq;
        @(negedge clk);
        tc_nx = counter_tc;
        cnt_clk[i] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ack(input logic [N_CH-1:0] a);
        @(negedge clk);
        irq_ack = a;
        @(negedge clk);
        irq_ack = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RSTN = 1'b0;
        cnt_clk = '0;
        irq_ack = '0;
        bus.counter_we = 1'b0;
        bus.counter_ch = '0;
        bus.counter_val = '0;

        // Reset with active tick sources
        repeat (6) begin
            @(negedge clk);
            cnt_clk = ~cnt_clk;
        end
        #1;
        chk("rst_out", 32'(bus.counter_out), 0);
        chk("rst_tc", 32'(counter_tc), 0);
        chk("rst_pend", 32'(irq_pend), 0);
        chk("rst_irq", 32'(irq), 0);
        @(negedge clk);
        RSTN = 1'b1;
        repeat (8) begin
            @(negedge clk);
            cnt_clk = ~cnt_clk;
        end
        cnt_clk = '0;
        repeat (4) @(negedge clk);
        chk_cnt("idle_ch0", 0, 0);
        chk_cnt("idle_ctrl", 3, 0);
        chk("idle_tc", 32'(counter_tc), 0);
        chk("idle_irq", 32'(irq), 0);

        // One-shot on channel 0
        wr(0, 3);
        wr(3, 32'h004);
        chk_cnt("os_load", 0, 3);
        pulse(0, '0);
        chk_cnt("os_p1", 0, 2);
        pulse(0, '0);
        chk_cnt("os_p2", 0, 1);
        chk("os_p2_tc", 32'(tc_at[0]), 0);
        pulse(0, '0);
        chk_cnt("os_p3", 0, 0);
        chk("os_p3_tc", 32'(tc_at[0]), 1);
        chk("os_p3_pend", 32'(pend_at[0]), 1);
        chk("os_p3_irq", 32'(irq_at), 0);
        pulse(0, '0);
        chk_cnt("os_p4", 0, 0);
        chk("os_p4_tc", 32'(counter_tc[0]), 1);
        ack(3'b001);
        chk("os_ack", 32'(irq_pend), 0);

        // Auto-reload with interrupt on channel 1
        wr(1, 2);
        wr(3, 32'h0D4);
        chk("ar_keep_tc0", 32'(counter_tc[0]), 1);
        pulse(1, '0);
        chk_cnt("ar_p1", 1, 1);
        chk("ar_p1_tc", 32'(tc_at[1]), 0);
        pulse(1, '0);
        chk_cnt("ar_p2", 1, 2);
        chk("ar_p2_tc", 32'(tc_at[1]), 1);
        chk("ar_p2_tcw", 32'(tc_nx[1]), 0);
        chk("ar_p2_irq", 32'(irq_at), 1);
        pulse(1, '0);
        chk("ar_p3_tc", 32'(tc_at[1]), 0);
        pulse(1, 3'b010);
        chk("ar_p4_tc", 32'(tc_at[1]), 1);
        chk("ar_p4_pend", 32'(pend_at[1]), 1);
        ack(3'b010);
        chk("ar_ack_pend", 32'(irq_pend), 0);
        chk("ar_ack_irq", 32'(irq), 0);
        pulse(1, '0);
        pulse(1, '0);
        chk("ar_p6_tc", 32'(tc_at[1]), 1);
        chk("ar_p6_tcw", 32'(tc_nx[1]), 0);
        chk_cnt("ar_p6", 1, 2);
        ack(3'b010);

        // Square wave on channel 2
        wr(2, 4);
        wr(3, 32'h6D4);
        repeat (3) pulse(2, '0);
        chk_cnt("sq_p3", 2, 1);
        chk("sq_p3_tc", 32'(counter_tc[2]), 0);
        pulse(2, '0);
        chk_cnt("sq_p4", 2, 4);
        chk("sq_p4_tc", 32'(counter_tc[2]), 1);
        chk("sq_p4_pend", 32'(irq_pend[2]), 1);
        chk("sq_p4_irq", 32'(irq), 0);
        repeat (3) pulse(2, '0);
        chk("sq_p7_tc", 32'(counter_tc[2]), 1);
        pulse(2, '0);
        chk("sq_p8_tc", 32'(counter_tc[2]), 0);

        // Free-running up counter on channel 0
        wr(3, 32'h6D7);
        wr(0, 32'hFE);
        chk("fr_load_tc", 32'(counter_tc[0]), 1);
        pulse(0, '0);
        chk_cnt("fr_p1", 0, 8'hFF);
        chk("fr_p1_pend", 32'(pend_at[0]), 0);
        pulse(0, '0);
        chk_cnt("fr_p2", 0, 0);
        chk("fr_p2_tc", 32'(counter_tc[0]), 0);
        chk("fr_p2_pend", 32'(pend_at[0]), 1);

        // Load colliding with a tick, control and select corners
        wr(3, 32'h6D4);
        chk_cnt("co_modekeep", 0, 0);
        wr(0, 9);
        @(negedge clk);
        cnt_clk[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.counter_we  = 1'b1;
        bus.counter_ch  = 3'd0;
        bus.counter_val = 5;
        @(negedge clk);
        bus.counter_we = 1'b0;
        @(negedge clk);
        cnt_clk[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt("co_load", 0, 5);
        pulse(0, '0);
        chk_cnt("co_tick", 0, 4);
        wr(3, 32'h6D4);
        chk_cnt("co_ctrl_same", 0, 4);
        chk_cnt("co_rd3", 3, 8'hD4);
        chk_cnt("co_rd6", 6, 8'hD4);
        wr(5, 32'hFF);
        chk_cnt("co_wr5_ch0", 0, 4);
        chk_cnt("co_wr5_ctrl", 3, 8'hD4);

        // Reset in the middle of channel 1 auto-reload
        chk("mr_pend_pre", 32'(irq_pend), 3'b101);
        bus.counter_ch = 3'd1;
        @(negedge clk);
        cnt_clk[1] = 1'b1;
        @(negedge clk);
        RSTN = 1'b0;
        #1;
        chk("mr_out", 32'(bus.counter_out), 0);
        chk("mr_pend", 32'(irq_pend), 0);
        chk("mr_tc", 32'(counter_tc), 0);
        chk("mr_irq", 32'(irq), 0);
        @(negedge clk);
        RSTN = 1'b1;
        cnt_clk[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt("mr_ctrl", 3, 0);
        pulse(1, '0);
        pulse(1, '0);
        chk_cnt("mr_noct", 1, 0);
        chk("mr_post_pend", 32'(irq_pend), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
